// File: rtl/frame_buffer_ctrl.sv
// Double-buffered framebuffer controller: maps rendered pixels into the back bank,
// counts them to detect frame completion, and swaps banks on the display vsync.
module frame_buffer_ctrl #(
   parameter int DISPLAY_WIDTH  = 320,
   parameter int DISPLAY_HEIGHT = 240,
   parameter int H_BITS         = 9,
   parameter int V_BITS         = 8,
   parameter int COLOR_BITS     = 4,
   parameter int ADDR_BITS      = 17
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [H_BITS-1:0]     px_hcount_in,
   input  logic [V_BITS-1:0]     px_vcount_in,
   input  logic [COLOR_BITS-1:0] px_color_in,
   input  logic                  px_valid_in,
   input  logic                  new_frame_in,
   input  logic                  vsync_in,
   input  logic                  err_clr_in,
   output logic                  wr_en_out,
   output logic [ADDR_BITS-1:0]  wr_addr_out,
   output logic [COLOR_BITS-1:0] wr_data_out,
   output logic                  wr_buf_out,
   output logic                  rd_buf_out,
   output logic                  stall_out,
   output logic                  frame_done_out,
   output logic                  err_out
);

   localparam int TOTAL_PX  = DISPLAY_WIDTH * DISPLAY_HEIGHT;
   localparam int CNT_BITS  = $clog2(TOTAL_PX + 1);
   localparam int PROD_BITS = V_BITS + H_BITS + $clog2(DISPLAY_WIDTH + 1);

   localparam logic [H_BITS-1:0]   H_LIMIT  = H_BITS'(DISPLAY_WIDTH);
   localparam logic [V_BITS-1:0]   V_LIMIT  = V_BITS'(DISPLAY_HEIGHT);
   localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(TOTAL_PX);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_RENDER     = 2'd1,
      ST_WAIT_VSYNC = 2'd2,
      ST_SWAP       = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [CNT_BITS-1:0]     r_cnt;
   logic [CNT_BITS-1:0]     w_cnt_next;
   logic [CNT_BITS-1:0]     w_cnt_base;
   logic                    w_in_range;
   logic                    w_accept;
   logic                    w_err_set;
   logic [ADDR_BITS-1:0]    w_addr;

   logic                    r_wr_en;
   logic [ADDR_BITS-1:0]    r_wr_addr;
   logic [COLOR_BITS-1:0]   r_wr_data;
   logic                    r_rd_buf;
   logic                    r_wr_buf;
   logic                    r_stall;
   logic                    r_frame_done;
   logic                    r_err;

   assign w_in_range = (px_hcount_in < H_LIMIT) && (px_vcount_in < V_LIMIT);

   // Row-major address formed at full product width before truncation.
   assign w_addr = ADDR_BITS'(PROD_BITS'(px_vcount_in) * PROD_BITS'(DISPLAY_WIDTH)
                              + PROD_BITS'(px_hcount_in));

   // Next-state, pixel acceptance and error detection.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_cnt_base   = r_cnt;
      w_accept     = 1'b0;
      w_err_set    = 1'b0;
      case (r_state)
         ST_IDLE, ST_RENDER: begin
            if ((r_state == ST_IDLE) && !new_frame_in) begin
               if (px_valid_in) begin
                  w_err_set = 1'b1;
               end else begin
                  w_err_set = 1'b0;
               end
            end else begin
               // A new_frame mid-render is a restart: flag it and count from zero.
               if ((r_state == ST_RENDER) && new_frame_in) begin
                  w_err_set = 1'b1;
               end else begin
                  w_err_set = 1'b0;
               end
               if (new_frame_in) begin
                  w_cnt_base = '0;
               end else begin
                  w_cnt_base = r_cnt;
               end
               w_cnt_next   = w_cnt_base;
               w_state_next = ST_RENDER;
               if (px_valid_in) begin
                  if (w_in_range) begin
                     w_accept   = 1'b1;
                     w_cnt_next = w_cnt_base + CNT_BITS'(1);
                     if ((w_cnt_base + CNT_BITS'(1)) == CNT_FULL) begin
                        w_state_next = ST_WAIT_VSYNC;
                     end else begin
                        w_state_next = ST_RENDER;
                     end
                  end else begin
                     w_err_set = 1'b1;
                  end
               end else begin
                  w_accept = 1'b0;
               end
            end
         end
         ST_WAIT_VSYNC: begin
            if (px_valid_in || new_frame_in) begin
               w_err_set = 1'b1;
            end else begin
               w_err_set = 1'b0;
            end
            if (vsync_in) begin
               w_state_next = ST_SWAP;
            end else begin
               w_state_next = ST_WAIT_VSYNC;
            end
         end
         ST_SWAP: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // FSM state and pixel counter.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // BRAM write port, one cycle behind pixel acceptance.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_accept;
         if (w_accept) begin
            r_wr_addr <= w_addr;
            r_wr_data <= px_color_in;
         end else begin
            r_wr_addr <= r_wr_addr;
            r_wr_data <= r_wr_data;
         end
      end
   end

   // Bank selection, stall and swap pulse; the swap becomes visible in the SWAP cycle.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_rd_buf     <= 1'b0;
         r_wr_buf     <= 1'b1;
         r_stall      <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_stall      <= (w_state_next == ST_WAIT_VSYNC) || (w_state_next == ST_SWAP);
         r_frame_done <= (w_state_next == ST_SWAP);
         if (w_state_next == ST_SWAP) begin
            r_rd_buf <= ~r_rd_buf;
            r_wr_buf <= ~r_wr_buf;
         end else begin
            r_rd_buf <= r_rd_buf;
            r_wr_buf <= r_wr_buf;
         end
      end
   end

   // Sticky error flag; a fresh error outranks a same-cycle clear.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end else if (err_clr_in) begin
         r_err <= 1'b0;
      end else begin
         r_err <= r_err;
      end
   end

   assign wr_en_out      = r_wr_en;
   assign wr_addr_out    = r_wr_addr;
   assign wr_data_out    = r_wr_data;
   assign wr_buf_out     = r_wr_buf;
   assign rd_buf_out     = r_rd_buf;
   assign stall_out      = r_stall;
   assign frame_done_out = r_frame_done;
   assign err_out        = r_err;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed self-checking bench for frame_buffer_ctrl on a 5x3 display.
module tb_frame_buffer_ctrl;

   localparam int W  = 5;
   localparam int H  = 3;
   localparam int HB = 9;
   localparam int VB = 8;
   localparam int CB = 4;
   localparam int AB = 4;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic [HB-1:0] px_hcount_in;
   logic [VB-1:0] px_vcount_in;
   logic [CB-1:0] px_color_in;
   logic          px_valid_in;
   logic          new_frame_in;
   logic          vsync_in;
   logic          err_clr_in;
   logic          wr_en_out;
   logic [AB-1:0] wr_addr_out;
   logic [CB-1:0] wr_data_out;
   logic          wr_buf_out;
   logic          rd_buf_out;
   logic          stall_out;
   logic          frame_done_out;
   logic          err_out;

   int n_checks = 0;
   int n_fail   = 0;

   frame_buffer_ctrl #(
      .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(HB), .V_BITS(VB),
      .COLOR_BITS(CB), .ADDR_BITS(AB)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .px_hcount_in(px_hcount_in), .px_vcount_in(px_vcount_in),
      .px_color_in(px_color_in), .px_valid_in(px_valid_in),
      .new_frame_in(new_frame_in), .vsync_in(vsync_in), .err_clr_in(err_clr_in),
      .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
      .wr_buf_out(wr_buf_out), .rd_buf_out(rd_buf_out), .stall_out(stall_out),
      .frame_done_out(frame_done_out), .err_out(err_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic clear_in();
      px_valid_in  = 1'b0;
      new_frame_in = 1'b0;
      vsync_in     = 1'b0;
      err_clr_in   = 1'b0;
   endtask

   task automatic pix(input int idx);
      px_valid_in  = 1'b1;
      px_hcount_in = HB'(idx % W);
      px_vcount_in = VB'(idx / W);
      px_color_in  = CB'(idx + 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_wr_en"},   32'(wr_en_out),      0);
      chk({tag, "_addr"},    32'(wr_addr_out),    0);
      chk({tag, "_data"},    32'(wr_data_out),    0);
      chk({tag, "_rd_buf"},  32'(rd_buf_out),     0);
      chk({tag, "_wr_buf"},  32'(wr_buf_out),     1);
      chk({tag, "_stall"},   32'(stall_out),      0);
      chk({tag, "_done"},    32'(frame_done_out), 0);
      chk({tag, "_err"},     32'(err_out),        0);
   endtask

   initial begin
      clear_in();
      px_hcount_in = '0;
      px_vcount_in = '0;
      px_color_in  = '0;
      rst_in       = 1'b0;
      repeat (2) tick();
      chk_reset("rst0");
      rst_in = 1'b1;
      tick();

      // Address map: first pixel arrives with new_frame.
      new_frame_in = 1'b1;
      px_valid_in  = 1'b1;
      px_hcount_in = HB'(4);
      px_vcount_in = VB'(2);
      px_color_in  = CB'(7);
      tick();
      clear_in();
      chk("map_wr_en",  32'(wr_en_out),   1);
      chk("map_addr",   32'(wr_addr_out), 14);
      chk("map_data",   32'(wr_data_out), 7);
      chk("map_wr_buf", 32'(wr_buf_out),  1);
      chk("map_err",    32'(err_out),     0);

      // Out-of-range column.
      px_valid_in  = 1'b1;
      px_hcount_in = HB'(5);
      px_vcount_in = VB'(0);
      tick();
      clear_in();
      chk("oor_wr_en", 32'(wr_en_out), 0);
      chk("oor_err",   32'(err_out),   1);
      err_clr_in = 1'b1;
      tick();
      clear_in();
      chk("clr_err", 32'(err_out), 0);

      // Remaining 14 pixels; the out-of-range one must not have counted.
      for (int i = 0; i < 14; i++) begin
         pix(i);
         tick();
         chk("ff_wr_en", 32'(wr_en_out),   1);
         chk("ff_addr",  32'(wr_addr_out), 32'(i));
         chk("ff_data",  32'(wr_data_out), 32'((i + 1) % 16));
         chk("ff_stall", 32'(stall_out),   32'(i == 13));
      end
      clear_in();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("wait_stall", 32'(stall_out),      1);
         chk("wait_done",  32'(frame_done_out), 0);
         chk("wait_wr_en", 32'(wr_en_out),      0);
      end
      vsync_in = 1'b1;
      tick();
      clear_in();
      chk("swap_done",   32'(frame_done_out), 1);
      chk("swap_rd_buf", 32'(rd_buf_out),     1);
      chk("swap_wr_buf", 32'(wr_buf_out),     0);
      chk("swap_stall",  32'(stall_out),      1);
      tick();
      chk("post_done",   32'(frame_done_out), 0);
      chk("post_stall",  32'(stall_out),      0);
      chk("post_rd_buf", 32'(rd_buf_out),     1);

      // Pixel while IDLE is dropped.
      pix(0);
      tick();
      clear_in();
      chk("idle_wr_en", 32'(wr_en_out), 0);
      chk("idle_err",   32'(err_out),   1);
      err_clr_in = 1'b1;
      tick();
      clear_in();
      chk("idle_clr", 32'(err_out), 0);

      // Asynchronous reset in the middle of a frame.
      new_frame_in = 1'b1;
      pix(0);
      tick();
      new_frame_in = 1'b0;
      pix(1);
      tick();
      pix(2);
      tick();
      clear_in();
      chk("pre_rst_wr_en",  32'(wr_en_out),  1);
      chk("pre_rst_wr_buf", 32'(wr_buf_out), 0);
      rst_in = 1'b0;
      #2;
      chk_reset("rst_mid");
      @(negedge clk_in);
      rst_in = 1'b1;
      tick();

      // Restart after 7 pixels.
      new_frame_in = 1'b1;
      pix(0);
      tick();
      new_frame_in = 1'b0;
      chk("rs_wr_buf", 32'(wr_buf_out), 1);
      chk("rs_addr",   32'(wr_addr_out), 0);
      for (int i = 1; i < 7; i++) begin
         pix(i);
         tick();
      end
      clear_in();
      new_frame_in = 1'b1;
      tick();
      clear_in();
      chk("rs_err",   32'(err_out),   1);
      chk("rs_stall", 32'(stall_out), 0);
      chk("rs_wr_en", 32'(wr_en_out), 0);
      err_clr_in = 1'b1;
      tick();
      clear_in();
      chk("rs_clr", 32'(err_out), 0);

      // 15 fresh pixels, vsync coincident with the last one.
      for (int i = 0; i < 15; i++) begin
         pix(i);
         if (i == 14) vsync_in = 1'b1;
         tick();
         chk("rs_stall_i", 32'(stall_out),   32'(i == 14));
         chk("rs_addr_i",  32'(wr_addr_out), 32'(i));
      end
      clear_in();
      chk("co_done", 32'(frame_done_out), 0);
      pix(3);
      tick();
      clear_in();
      chk("wv_err",   32'(err_out),        1);
      chk("wv_wr_en", 32'(wr_en_out),      0);
      chk("wv_stall", 32'(stall_out),      1);
      chk("wv_done",  32'(frame_done_out), 0);
      tick();
      chk("co_done2",  32'(frame_done_out), 0);
      chk("co_rd_buf", 32'(rd_buf_out),     0);
      vsync_in = 1'b1;
      tick();
      clear_in();
      chk("co_swap_done",   32'(frame_done_out), 1);
      chk("co_swap_rd_buf", 32'(rd_buf_out),     1);
      chk("co_swap_wr_buf", 32'(wr_buf_out),     0);
      tick();
      chk("co_post_stall", 32'(stall_out),      0);
      chk("co_post_done",  32'(frame_done_out), 0);
      chk("co_post_err",   32'(err_out),        1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
